// File: rtl/cfg_scan_loader.sv
// Scan-chain configuration loader: takes bitstream words over valid/ready,
// shifts them MSB-first into the fabric chain and returns the displaced bits as readback words.
module cfg_scan_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BIT_W  = $clog2(WORD_W);
  localparam int unsigned WCNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-2:0]   rbreg_q, rbreg_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [WORD_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                last_bit_c;
  logic                last_word_c;

  // State and datapath registers
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      rbreg_q    <= '0;
      bit_idx_q  <= '0;
      word_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      rbreg_q    <= rbreg_d;
      bit_idx_q  <= bit_idx_d;
      word_cnt_q <= word_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign last_bit_c  = (bit_idx_q == BIT_W'(WORD_W - 1));
  assign last_word_c = (word_cnt_q == WCNT_W'(NUM_WORDS - 1));

  // Next state; handshake and scan strobes decode only registered state
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rbreg_d    = rbreg_q;
    bit_idx_d  = bit_idx_q;
    word_cnt_d = word_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    word_ready = 1'b0;
    scan_en    = 1'b0;
    scan_in    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (abort) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end else if (start) begin
          state_d    = S_FETCH;
          word_cnt_d = '0;
          tmo_cnt_d  = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      S_FETCH: begin
        word_ready = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (word_valid) begin
          state_d   = S_SHIFT;
          shreg_d   = word_data;
          bit_idx_d = '0;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_SHIFT: begin
        scan_en    = 1'b1;
        scan_in    = shreg_q[WORD_W-1];
        word_ready = last_bit_c && !last_word_c;
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          shreg_d   = shreg_q << 1;
          rbreg_d   = {rbreg_q[WORD_W-3:0], scan_out};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (last_bit_c) begin
            rb_data_d  = {rbreg_q, scan_out};
            rb_valid_d = 1'b1;
            word_cnt_d = word_cnt_q + WCNT_W'(1);
            bit_idx_d  = '0;
            if (last_word_c) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else if (word_valid) begin
              // Next word queued: keep shifting with no bubble
              shreg_d = word_data;
            end else begin
              state_d   = S_FETCH;
              tmo_cnt_d = '0;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
